uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one RS232 byte transmitter among N_REQ requesters, such as the sample-memory sender and a status/debug reporter. Requesters hand over bytes with a request/ack handshake. The arbiter fires the transmitter's one-cycle send pulse, waits for its done strobe, and then acks. Grant is held for a whole packet, ending at the byte flagged last, and priority rotates round-robin between packets.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 65535, cycles allowed between oTxSend and iTxDone (used only with the optional feature)

Ports:
iClock  in  1  system clock, rising edge
iReset  in  1  asynchronous, active-high reset
iReq  in  N_REQ  per-requester byte request; held until acked or until the requester abandons the packet
iData  in  8*N_REQ  requester i byte on iData[8i+7:8i]
iLast  in  N_REQ  requester i current byte ends its packet
oAck  out  N_REQ  one-cycle pulse: byte consumed; the requester may present the next byte
oGrant  out  N_REQ  one-hot, owner of the transmitter; all zero when idle
oTxData  out  8  byte to the transmitter
oTxSend  out  1  one-cycle send pulse to the transmitter
iTxDone  in  1  transmitter finished the byte (one-cycle pulse)
oBusy  out  1  high in any state except IDLE
oError  out  1  sticky timeout flag; constant 0 when the optional feature is compiled out

Behaviour:
- Reset (async, immediate):
  - All outputs go to 0.
  - State goes to IDLE.
  - Priority pointer goes to 0, so requester 0 ranks highest.
  - A byte in flight is dropped with no ack.
- States: IDLE, LOAD, WAIT_DONE, GAP.
- IDLE:
  - If any iReq is high, pick the first requesting index at or after the pointer, wrapping modulo N_REQ.
  - Register oGrant one-hot for the winner and latch the winner's iLast into last_r.
  - Go to LOAD. Latency is 1 edge from iReq to oGrant.
- LOAD:
  - oTxData <= granted iData.
  - oTxSend <= 1 for exactly one cycle.
  - Go to WAIT_DONE.
  - oTxData stays stable until the next LOAD.
- WAIT_DONE:
  - oTxSend is 0.
  - iTxDone is honoured only from the first cycle of WAIT_DONE. A done seen during LOAD is ignored.
  - On iTxDone: pulse oAck for the granted index for 1 cycle.
    - If last_r is set: clear oGrant, set pointer = granted+1 mod N_REQ, go to IDLE.
    - Otherwise: go to GAP.
- GAP (one cycle, lets the requester update data after the ack):
  - If the granted iReq is high: latch iLast into last_r and go to LOAD.
  - If it is low (packet abandoned): clear oGrant, rotate the pointer, go to IDLE.
- Requests from non-granted requesters are ignored until the grant is released. They need not stay asserted for fairness.
- Two requesters going high in the same cycle: the pointer order decides.
- Pointer wrap: after the grant to N_REQ-1, the pointer becomes 0.
- A single-byte packet (iLast high on the first byte) releases after one byte.
- The minimum interval between consecutive oTxSend pulses within a packet is 3 cycles plus the transmitter time.

Optional Feature:
UART_TX_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears in LOAD and increments in WAIT_DONE.
  - When the count reaches TIMEOUT_CYCLES without iTxDone, the block gives no ack and sets oError (sticky until iReset).
  - It then clears oGrant, rotates the pointer, and goes to IDLE.
- Undefined: no counter exists, WAIT_DONE waits indefinitely, and oError is tied to 0.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE=2'b00, LOAD=2'b01, WAIT_DONE=2'b10, GAP=2'b11).
  - BYTE_W=8.
  - The default TIMEOUT_CYCLES.
- Sub-module rr_pick (purely combinational) takes the request vector and pointer and returns the one-hot winner plus a valid flag. It is reusable by other arbiters.

Test Plan:
- Reset: assert iReset mid-WAIT_DONE with oGrant=0010. All outputs go to 0 asynchronously, and after release the next grant goes to requester 0 first.
- Single packet: req1 sends 0x41,0x42,0x43 with last on 0x43 and a transmitter model giving done 10 cycles after send. Required: three oTxSend pulses carrying those bytes, three oAck[1] pulses, then oGrant=0000 and oBusy=0.
- Round-robin: req0 and req2 both continuously send 1-byte packets. Required grant order 0,2,0,2; req2 is never starved.
- Simultaneous: req3 and req1 rise in the same cycle with pointer=2. Required: the grant goes to 3 first, then to 1.
- Abandon: req0 drops iReq after its first ack with last=0. Required: GAP releases the grant, the pointer becomes 1, and no extra oTxSend occurs.
- Timeout (macro defined, TIMEOUT_CYCLES=20): iTxDone is never given. Required: oError rises 20 cycles after WAIT_DONE entry, there is no oAck, and oGrant clears.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_pkg
//  Description : Shared definitions for the UART transmit arbiter: FSM state
//                encoding, byte width and the default done-timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD      = 2'b01,
    ST_WAIT_DONE = 2'b10,
    ST_GAP       = 2'b11
  } state_t;

  localparam int BYTE_W                 = 8;
  localparam int TIMEOUT_CNT_W          = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first active
//                request at or after the pointer, wrapping modulo N.
//  Ports       : req   - request vector
//                ptr   - highest-priority index (must be < N)
//                grant - one-hot winner, all zero when no request
//                valid - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  // Rotate so that bit 0 is the requester at ptr, pick the lowest set bit,
  // then rotate the one-hot result back. Doubling the vector makes the
  // rotation work for non-power-of-two N as long as ptr < N.
  logic [N-1:0] rot;
  logic [N-1:0] oh;

  assign rot = N'({req, req} >> ptr);

  always_comb begin
    oh = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        oh    = '0;
        oh[k] = 1'b1;
      end
    end
  end

  assign grant = N'(({oh, oh} << ptr) >> N);
  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one byte transmitter among N_REQ requesters. A grant
//                is held for a whole packet (until the byte flagged last or
//                until the requester drops its request); priority rotates
//                round-robin between packets.
//  Ports       : iClock/iReset      - clock, async active-high reset
//                iReq/iData/iLast   - per-requester byte handshake inputs
//                oAck               - one-cycle byte-consumed pulse
//                oGrant             - one-hot current owner
//                oTxData/oTxSend    - byte and send pulse to transmitter
//                iTxDone            - transmitter finished byte
//                oBusy              - arbiter not idle
//                oError             - sticky done-timeout flag
//  Options     : UART_TX_ARB_TIMEOUT_EN - enables the done timeout; when not
//                defined the arbiter waits for iTxDone indefinitely and
//                oError is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic [N_REQ-1:0]        iReq,
  input  logic [BYTE_W*N_REQ-1:0] iData,
  input  logic [N_REQ-1:0]        iLast,
  output logic [N_REQ-1:0]        oAck,
  output logic [N_REQ-1:0]        oGrant,
  output logic [BYTE_W-1:0]       oTxData,
  output logic                    oTxSend,
  input  logic                    iTxDone,
  output logic                    oBusy,
  output logic                    oError
);

  localparam int PTR_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("uart_tx_arbiter: N_REQ must be 2..8, TIMEOUT_CYCLES 1..65535");
  end

  state_t             state, state_n;
  logic [N_REQ-1:0]   grant_n, ack_n;
  logic [BYTE_W-1:0]  tx_data_n;
  logic               tx_send_n;
  logic               last_r, last_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [PTR_W-1:0]   gidx, gidx_next;
  logic [N_REQ-1:0]   pick;
  logic               pick_valid;
  logic [BYTE_W-1:0]  sel_data;
  logic               sel_last;
  logic               sel_req;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] cnt, cnt_n;
  logic                     err_n;
`endif

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (iReq),
    .ptr   (ptr),
    .grant (pick),
    .valid (pick_valid)
  );

  // Index and inputs of the current owner.
  always_comb begin
    gidx     = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oGrant[i]) begin
        gidx     = PTR_W'(i);
        sel_data = iData[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign sel_last  = |(iLast & oGrant);
  assign sel_req   = |(iReq & oGrant);
  assign gidx_next = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);
  assign oBusy     = (state != ST_IDLE);

  always_comb begin
    state_n   = state;
    grant_n   = oGrant;
    ack_n     = '0;
    tx_data_n = oTxData;
    tx_send_n = 1'b0;
    last_n    = last_r;
    ptr_n     = ptr;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_n     = cnt;
    err_n     = oError;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_n = pick;
          last_n  = |(iLast & pick);
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_data_n = sel_data;
        tx_send_n = 1'b1;
        state_n   = ST_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_n     = '0;
`endif
      end
      ST_WAIT_DONE: begin
        if (iTxDone) begin
          ack_n = oGrant;
          if (last_r) begin
            grant_n = '0;
            ptr_n   = gidx_next;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_GAP;
          end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        // The count reaches TIMEOUT_CYCLES on this edge: give up on the byte.
        else if (cnt == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_n   = 1'b1;
          grant_n = '0;
          ptr_n   = gidx_next;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + TIMEOUT_CNT_W'(1);
        end
`endif
      end
      ST_GAP: begin
        // The requester saw oAck during this cycle and has either presented
        // its next byte or withdrawn its request.
        if (sel_req) begin
          last_n  = sel_last;
          state_n = ST_LOAD;
        end else begin
          grant_n = '0;
          ptr_n   = gidx_next;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state   <= ST_IDLE;
      oGrant  <= '0;
      oAck    <= '0;
      oTxData <= '0;
      oTxSend <= 1'b0;
      last_r  <= 1'b0;
      ptr     <= '0;
    end else begin
      state   <= state_n;
      oGrant  <= grant_n;
      oAck    <= ack_n;
      oTxData <= tx_data_n;
      oTxSend <= tx_send_n;
      last_r  <= last_n;
      ptr     <= ptr_n;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      cnt    <= '0;
      oError <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      oError <= err_n;
    end
  end
`else
  assign oError = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. Requesters are
//                driven from packet tables; a reference model predicts the
//                byte/ack order from round-robin packet rules and a monitor
//                compares every oTxSend and oAck against it.
//  Options     : UART_TX_ARB_TIMEOUT_EN - also exercises the done timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N = 4;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 65535;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, last, ack, grant;
  logic [8*N-1:0] data;
  logic [7:0]     tx_data;
  logic           tx_send, tx_done, busy, err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .iClock  (clk),
    .iReset  (rst),
    .iReq    (req),
    .iData   (data),
    .iLast   (last),
    .oAck    (ack),
    .oGrant  (grant),
    .oTxData (tx_data),
    .oTxSend (tx_send),
    .iTxDone (tx_done),
    .oBusy   (busy),
    .oError  (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- requester tables ----------------
  logic [7:0] pb    [N][8];
  int         plen  [N];
  int         pstop [N];   // bytes sent before the packet ends or is abandoned
  int         pos   [N];
  bit         active[N];

  // ---------------- reference model ----------------
  typedef struct {
    int         idx;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   mptr = 0;

  // Packets of every requester in 'set' start together while the arbiter is
  // idle, so they are served whole, in cyclic order from the pointer.
  task automatic issue(input logic [N-1:0] set);
    int   start;
    int   lastidx;
    exp_t e;
    start   = mptr;
    lastidx = mptr;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (set[i]) begin
        for (int j = 0; j < pstop[i]; j++) begin
          e.idx = i;
          e.b   = pb[i][j];
          exp_q.push_back(e);
          ack_q.push_back(i);
        end
        lastidx = i;
      end
    end
    mptr = (lastidx + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (set[i]) begin
        pos[i]    = 0;
        active[i] = 1'b1;
      end
    end
  endtask

  task automatic rand_pkt(input int i);
    plen[i]  = $urandom_range(1, 4);
    pstop[i] = plen[i];
    if (plen[i] > 1 && $urandom_range(0, 4) == 0) pstop[i] = $urandom_range(1, plen[i] - 1);
    for (int j = 0; j < 8; j++) pb[i][j] = 8'($urandom);
  endtask

  function automatic bit any_active();
    bit a;
    a = 1'b0;
    for (int i = 0; i < N; i++) a |= active[i];
    return a;
  endfunction

  // ---------------- requester driver ----------------
  initial begin
    req  = '0;
    data = '0;
    last = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (active[i] && ack[i] && !rst) begin
          pos[i]++;
          if (pos[i] >= pstop[i]) active[i] = 1'b0;
        end
        req[i]         = active[i];
        data[8*i +: 8] = active[i] ? pb[i][pos[i]] : 8'h00;
        last[i]        = active[i] && (pos[i] == plen[i] - 1);
      end
    end
  end

  // ---------------- transmitter model ----------------
  bit no_done     = 1'b0;
  int fixed_delay = 0;

  initial begin
    int tcnt;
    bit pend;
    tx_done = 1'b0;
    pend    = 1'b0;
    tcnt    = 0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        tcnt--;
        if (tcnt == 0) begin
          tx_done = 1'b1;
          pend    = 1'b0;
        end
      end else if (tx_send) begin
        if (!no_done) begin
          pend = 1'b1;
          tcnt = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 12));
        end
      end else if (!no_done && $urandom_range(0, 9) == 0) begin
        // Stray done while nothing is in flight; the arbiter must ignore it.
        tx_done = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_send) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_send: got data %02h grant %b, expected no send", tx_data, grant);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e.b));
            check("grant_at_send", 32'(grant), 32'(1) << e.idx);
          end
        end
        if (ack != '0) begin
          if (ack_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got %b, expected none", ack);
          end else begin
            a = ack_q.pop_front();
            check("ack", 32'(ack), 32'(1) << a);
          end
        end
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(exp_q.size() == 0 && ack_q.size() == 0 && !any_active() && !busy) && n < 3000);
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending sends, expected 0", name, exp_q.size());
      exp_q.delete();
      ack_q.delete();
    end
    check({name, "_grant_idle"}, 32'(grant), 32'(0));
    check({name, "_busy_idle"}, 32'(busy), 32'(0));
  endtask

  task automatic wait_send(input string name);
    int n;
    n = 0;
    while (!tx_send && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_send_seen"}, 32'(tx_send), 32'(1));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    exp_t e;
    int   n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_send", 32'(tx_send), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single three-byte packet from requester 1, done 10 cycles after send.
    fixed_delay = 10;
    pb[1][0] = 8'h41; pb[1][1] = 8'h42; pb[1][2] = 8'h43;
    plen[1] = 3; pstop[1] = 3;
    issue(4'b0010);
    wait_idle("single");

    // Pointer is now 2: requesters 3 and 1 together, 3 must win first.
    fixed_delay = 0;
    rand_pkt(1); plen[1] = 1; pstop[1] = 1;
    rand_pkt(3); plen[3] = 1; pstop[3] = 1;
    issue(4'b1010);
    @(posedge clk);
    #1;
    check("simul_first_grant", 32'(grant), 32'h8);
    wait_idle("simul");

    // Requester 0 abandons its packet after the first byte.
    rand_pkt(0); plen[0] = 3; pstop[0] = 1;
    issue(4'b0001);
    wait_idle("abandon");
    // Pointer should now be 1.
    rand_pkt(0); plen[0] = 1; pstop[0] = 1;
    rand_pkt(1); plen[1] = 1; pstop[1] = 1;
    issue(4'b0011);
    @(posedge clk);
    #1;
    check("after_abandon_grant", 32'(grant), 32'h2);
    wait_idle("after_abandon");

    // Requesters 0 and 2 repeatedly send single-byte packets.
    for (int r = 0; r < 4; r++) begin
      rand_pkt(0); plen[0] = 1; pstop[0] = 1;
      rand_pkt(2); plen[2] = 1; pstop[2] = 1;
      issue(4'b0101);
      wait_idle("rr");
    end

    // Randomized packet mixes.
    for (int p = 0; p < 25; p++) begin
      logic [N-1:0] set;
      set = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) if (set[i]) rand_pkt(i);
      issue(set);
      wait_idle("random");
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Transmitter never answers: timeout after 20 cycles in WAIT_DONE.
    no_done = 1'b1;
    pb[2][0] = 8'h5A; pb[2][1] = 8'hA5; plen[2] = 2; pstop[2] = 2;
    e.idx = 2; e.b = 8'h5A;
    exp_q.push_back(e);
    pos[2] = 0; active[2] = 1'b1;
    mptr = 3;
    wait_send("timeout");
    n = 0;
    while (!err && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd20);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_grant", 32'(grant), 32'd0);
    active[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    no_done = 1'b0;
    wait_idle("timeout");
    check("timeout_err_sticky", 32'(err), 32'd1);
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    // Reset in the middle of WAIT_DONE while requester 1 owns the transmitter.
    fixed_delay = 10;
    pb[1][0] = 8'hC3; pb[1][1] = 8'h3C; pb[1][2] = 8'h99;
    plen[1] = 3; pstop[1] = 3;
    e.idx = 1; e.b = 8'hC3;
    exp_q.push_back(e);
    pos[1] = 0; active[1] = 1'b1;
    wait_send("reset");
    @(posedge clk);
    #3;
    check("pre_reset_grant", 32'(grant), 32'h2);
    rst = 1'b1;
    #1;
    check("async_rst_grant", 32'(grant), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_send", 32'(tx_send), 0);
    check("async_rst_data", 32'(tx_data), 0);
    check("async_rst_ack", 32'(ack), 0);
    check("async_rst_err", 32'(err), 0);
    active[1] = 1'b0;
    mptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fixed_delay = 0;
    rand_pkt(0); plen[0] = 1; pstop[0] = 1;
    rand_pkt(1); plen[1] = 2; pstop[1] = 2;
    issue(4'b0011);
    @(posedge clk);
    #1;
    check("post_reset_grant", 32'(grant), 32'h1);
    wait_idle("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
